// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - one-wire frame transmitter: start 0, WIDTH data bits LSB first, stop 1.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
    logic             tx_out_q, tx_out_d;
    logic             tx_done_q, tx_done_d;
    logic             clk_last;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            clk_cnt_q <= '0;
            tx_out_q  <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            clk_cnt_q <= clk_cnt_d;
            tx_out_q  <= tx_out_d;
            tx_done_q <= tx_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        clk_cnt_d = clk_cnt_q;
        tx_out_d  = tx_out_q;
        tx_done_d = 1'b0;
        clk_last  = (clk_cnt_q == LAST_CLK);
        shifted   = shift_q >> 1;

        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                if (tx_valid) begin
                    shift_d   = tx_data;
                    state_d   = START;
                    tx_out_d  = 1'b0;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_last) begin
                    state_d   = DATA;
                    tx_out_d  = shift_q[0];
                    bit_cnt_d = '0;
                    clk_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (clk_last) begin
                    clk_cnt_d = '0;
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    // The next bit is taken from the post-shift LSB so it lands on the line at the bit boundary.
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d  = STOP;
                        tx_out_d = 1'b1;
                    end else begin
                        tx_out_d = shifted[0];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                tx_out_d = 1'b1;
                if (clk_last) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                    tx_done_d = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);
    assign tx_out   = tx_out_q;
    assign tx_done  = tx_done_q;

endmodule

// File: doc/serial_tx.md
# serial_tx

Frame-based serial transmitter that turns a parallel word into a one-wire bit stream: idle-high line, start bit 0, WIDTH data bits LSB first, stop bit 1. It is the sending end of the team's flip-flop-based serial link, and feeds the capture/receive flops on the far side. Words are accepted through a valid/ready handshake, and a one-cycle done pulse marks the end of each frame.

## Interface
- WIDTH, 8: data bits per frame; legal range ≥ 1.
- CLKS_PER_BIT, 4: clk cycles each bit is held on the line; legal range ≥ 1.

- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high; clock clk.
- tx_data  input  WIDTH  word to send; sampled only on an accepting edge.
- tx_valid  input  1  source has a word on tx_data.
- tx_ready  output  1  block can accept a word; high exactly when the FSM is in IDLE.
- tx_out  output  1  serial line, registered, idle level 1.
- tx_busy  output  1  high in START, DATA and STOP.
- tx_done  output  1  registered one-cycle pulse in the first IDLE cycle after STOP completes.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Internal registers:
  - shift register, WIDTH bits.
  - bit counter, clog2(WIDTH) bits (minimum 1).
  - clock counter, clog2(CLKS_PER_BIT) bits (minimum 1).
- IDLE:
  - tx_out=1, tx_ready=1.
  - A word is accepted on an edge where tx_valid && tx_ready. On that edge: tx_data is latched into the shift register, state moves to START, tx_out<=0 and the clock counter is cleared.
- START: tx_out held 0 for CLKS_PER_BIT cycles. On the last of these cycles: state moves to DATA, tx_out<=shift[0], bit counter<=0.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At the end of each bit the shift register shifts right and the bit counter increments.
  - When bit WIDTH-1 completes: state moves to STOP, tx_out<=1.
- STOP: tx_out held 1 for CLKS_PER_BIT cycles. Then state moves to IDLE, with tx_done<=1 for exactly one cycle.
- Data integrity: tx_data and tx_valid are ignored outside IDLE. The latched word is immune to changes on tx_data mid-frame.
- The source may drop tx_valid before acceptance without penalty; no word is sent.
- Back-to-back: if tx_valid is high in the done cycle, the next word is accepted on that edge. The gap between frames is therefore exactly 1 clk of idle-high line.
- Reset:
  - Values while rst is high: tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
  - The handshake is ignored while rst is high, so no word is accepted.
  - Reset mid-frame aborts the frame immediately (asynchronously). tx_out returns to 1 without waiting for a clock edge, and no tx_done is issued.
- CLKS_PER_BIT=1 must work: one cycle per bit, clock counter held at 0.

## Timing
- Let k be the accepting edge.
- Start bit: tx_out=0 from edge k to edge k+C, where C=CLKS_PER_BIT.
- Data bit i: on the line from edge k+(i+1)·C to edge k+(i+2)·C.
- Stop bit: from edge k+(WIDTH+1)·C to edge k+(WIDTH+2)·C.
- Frame length: (WIDTH+2)·C cycles. At edge k+(WIDTH+2)·C the state is IDLE, and tx_done=1 and tx_ready=1 for that cycle.
- tx_busy is high from edge k to edge k+(WIDTH+2)·C.
- tx_ready and tx_busy are decoded from the state register (glitch-free, no input-to-output combinational path). tx_out and tx_done are flops.
- Throughput with tx_valid held high: one word per (WIDTH+2)·C+1 cycles.

## Test plan
- Reset state: assert rst mid-cycle with no clock edge -> tx_out=1, tx_ready=1, tx_busy=0 and tx_done=0 immediately.
- Single frame: WIDTH=8, C=4, send 0xA5 at edge k. Required line: 0×4, then 1,0,1,0,0,1,0,1 each ×4, then 1×4. tx_done=1 only in the cycle after edge k+40.
- Back-to-back frames: send 0x00 then 0xFF with tx_valid held high. The second start bit begins exactly 1 cycle after the first stop bit ends. tx_done pulses twice, 41 cycles apart.
- Mid-frame interference: tx_valid=1 and tx_data=0x3C toggling during the frame of 0x81. The line carries 0x81 only, and 0x3C is accepted only in the done cycle.
- Reset mid-frame: assert rst during data bit 3 -> tx_out=1 at once and no tx_done. After release, 0x5A sends correctly.
- C=1, WIDTH=8: send 0xC3 -> 10-cycle frame 0,1,1,0,0,0,0,1,1,1. tx_done arrives at k+10.
